// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - shared helpers for the dual-clock FIFO controllers
// Purpose: width helper and Gray/binary conversions shared by the write and
//          read side controllers.
// Contents:
//   clog2     - ceiling log2, usable in parameter expressions
//   bin2gray  - binary to reflected Gray code, up to PTR_MAX_W bits
//   gray2bin  - reflected Gray code to binary, up to PTR_MAX_W bits
// Narrower pointers are zero-extended into the helpers and cast back down by
// the caller; zero upper bits leave the conversions exact.
package async_fifo_pkg;

  localparam int PTR_MAX_W = 32;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
    logic [PTR_MAX_W-1:0] bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// rtl/gray_ptr_sync.sv - multi-flop synchroniser for a Gray-coded pointer
// Purpose: brings a Gray-coded pointer from a foreign clock domain into clk.
//          Used by both the write and read side controllers.
// Ports:
//   clk  in   destination-domain clock
//   rst  in   synchronous, active-high reset; clears every stage
//   d    in   WIDTH  Gray pointer from the other domain
//   q    out  WIDTH  synchronised pointer, SYNC_STAGES cycles behind
// Only one bit of d changes per source update, so each stage may go
// metastable on at most one bit and q is always an old or a new pointer.
// Stages are a pure flop chain with nothing in between.
module gray_ptr_sync #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// rtl/async_fifo_wr_ctrl.sv - write-side controller of a dual-clock FIFO
// Purpose: accepts a valid/ready stream in clka, drives the RAM write port
//          with zero latency, publishes a Gray write pointer and derives
//          full / almost_full / occupancy from the synchronised read pointer.
// Ports:
//   clka         in   write clock
//   rstb         in   synchronous, active-high reset
//   s_data       in   RAM_WIDTH  write data
//   s_valid      in   write request
//   s_ready      out  controller can accept (low in reset and when full)
//   rd_ptr_gray  in   AW+1  Gray read pointer from the clkb domain
//   addra        out  AW    RAM write address
//   dina         out  RAM_WIDTH  RAM write data
//   wea          out  RAM write enable
//   wr_ptr_gray  out  AW+1  registered Gray write pointer to the read domain
//   full         out  FIFO full
//   almost_full  out  occupancy >= ALMOST_FULL_THRESH
//   wr_count     out  AW+1  occupancy as seen from the write side
module async_fifo_wr_ctrl
  import async_fifo_pkg::*;
#(
  parameter  int RAM_WIDTH          = 36,
  parameter  int RAM_DEPTH          = 512,
  parameter  int SYNC_STAGES        = 2,
  parameter  int ALMOST_FULL_THRESH = RAM_DEPTH - 4,
  localparam int AW                 = clog2(RAM_DEPTH)
) (
  input  logic                 clka,
  input  logic                 rstb,
  input  logic [RAM_WIDTH-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [AW:0]          rd_ptr_gray,
  output logic [AW-1:0]        addra,
  output logic [RAM_WIDTH-1:0] dina,
  output logic                 wea,
  output logic [AW:0]          wr_ptr_gray,
  output logic                 full,
  output logic                 almost_full,
  output logic [AW:0]          wr_count
);

  localparam int PW = AW + 1;

  logic [PW-1:0] wbin;
  logic [PW-1:0] wgray;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rq;
  logic [PW-1:0] rbin;
  logic [PW-1:0] occ_next;
  logic [PW-1:0] full_match;

  gray_ptr_sync #(
    .WIDTH       (PW),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rd_ptr_sync (
    .clk (clka),
    .rst (rstb),
    .d   (rd_ptr_gray),
    .q   (rq)
  );

  // Handshake and RAM port are combinational so the RAM captures the word on
  // the same edge that accepts it.
  assign s_ready = !full && !rstb;
  assign wea     = s_valid && s_ready;
  assign addra   = wbin[AW-1:0];
  assign dina    = s_data;

  assign wbin_next  = wbin + PW'(wea);
  assign wgray_next = PW'(bin2gray(PTR_MAX_W'(wbin_next)));
  assign rbin       = PW'(gray2bin(PTR_MAX_W'(rq)));
  assign occ_next   = wbin_next - rbin;

  // Full when the writer is exactly one lap ahead: in Gray code that is the
  // read pointer with its two top bits inverted.
  assign full_match = {~rq[AW:AW-1], rq[AW-2:0]};

  always_ff @(posedge clka) begin
    if (rstb) begin
      wbin        <= '0;
      wgray       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_count    <= '0;
    end else begin
      wbin        <= wbin_next;
      wgray       <= wgray_next;
      full        <= (wgray_next == full_match);
      almost_full <= (occ_next >= PW'(ALMOST_FULL_THRESH));
      wr_count    <= occ_next;
    end
  end

  assign wr_ptr_gray = wgray;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// tb/tb_async_fifo_wr_ctrl.sv - self-checking bench for async_fifo_wr_ctrl
module tb_async_fifo_wr_ctrl;

  localparam int W = 36;

  logic          clka = 1'b0;
  logic          rstb;
  logic [W-1:0]  s_data;
  logic          s_valid;
  logic          s_ready;
  logic [3:0]    rd_ptr_gray;
  logic [2:0]    addra;
  logic [W-1:0]  dina;
  logic          wea;
  logic [3:0]    wr_ptr_gray;
  logic          full;
  logic          almost_full;
  logic [3:0]    wr_count;

  int total = 0;
  int bad   = 0;

  // Reference model: count of writes (mod 16), reader position, and the
  // reader position as the write side sees it two cycles later.
  logic [3:0] m_wr   = 4'd0;
  logic [3:0] rd_bin = 4'd0;
  logic [3:0] rq0    = 4'd0;
  logic [3:0] rq1    = 4'd0;
  logic [3:0] m_cnt  = 4'd0;
  logic       m_full = 1'b0;
  logic       m_af   = 1'b0;
  logic       m_wea  = 1'b0;

  async_fifo_wr_ctrl #(
    .RAM_WIDTH          (W),
    .RAM_DEPTH          (8),
    .SYNC_STAGES        (2),
    .ALMOST_FULL_THRESH (6)
  ) dut (
    .clka        (clka),
    .rstb        (rstb),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .rd_ptr_gray (rd_ptr_gray),
    .addra       (addra),
    .dina        (dina),
    .wea         (wea),
    .wr_ptr_gray (wr_ptr_gray),
    .full        (full),
    .almost_full (almost_full),
    .wr_count    (wr_count)
  );

  always #5 clka = ~clka;

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic set_rd(input logic [3:0] b);
    rd_bin      = b;
    rd_ptr_gray = to_gray(b);
  endtask

  // Advance one clka edge and update the model; returns at posedge+1.
  task automatic step();
    logic w;
    w = s_valid && !m_full && !rstb;
    @(posedge clka);
    m_wea = w;
    if (rstb) begin
      m_wr = 4'd0; rq0 = 4'd0; rq1 = 4'd0;
      m_cnt = 4'd0; m_full = 1'b0; m_af = 1'b0;
    end else begin
      m_wr   = m_wr + {3'd0, w};
      m_cnt  = m_wr - rq1;
      m_full = (m_cnt == 4'd8);
      m_af   = (m_cnt >= 4'd6);
      rq1    = rq0;
      rq0    = rd_bin;
    end
    #1;
  endtask

  task automatic test_reset();
    rstb = 1'b1; s_valid = 1'b1; s_data = 36'h5A5A5A5A5; set_rd(4'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", s_ready); end
      total++; if (wea !== 1'b0) begin bad++; $display("FAIL rst_wea: got %b want 0", wea); end
      step();
      total++; if (wr_ptr_gray !== 4'd0) begin bad++; $display("FAIL rst_wptr: got %h want 0", wr_ptr_gray); end
      total++; if (full !== 1'b0) begin bad++; $display("FAIL rst_full: got %b want 0", full); end
      total++; if (wr_count !== 4'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", wr_count); end
      total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL rst_af: got %b want 0", almost_full); end
    end
  endtask

  task automatic test_fill();
    rstb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1; s_data = W'(i + 1);
      #1;
      total++; if (wea !== 1'b1) begin bad++; $display("FAIL fill_wea[%0d]: got %b want 1", i, wea); end
      total++; if (addra !== 3'(i)) begin bad++; $display("FAIL fill_addr[%0d]: got %0d want %0d", i, addra, i); end
      total++; if (dina !== s_data) begin bad++; $display("FAIL fill_dina[%0d]: got %h want %h", i, dina, s_data); end
      step();
      total++; if (wr_count !== 4'(i + 1)) begin bad++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, wr_count, i + 1); end
      total++; if (almost_full !== (i >= 5)) begin bad++; $display("FAIL fill_af[%0d]: got %b want %b", i, almost_full, (i >= 5)); end
      total++; if (full !== (i == 7)) begin bad++; $display("FAIL fill_full[%0d]: got %b want %b", i, full, (i == 7)); end
      total++; if (wr_ptr_gray !== to_gray(m_wr)) begin bad++; $display("FAIL fill_wptr[%0d]: got %h want %h", i, wr_ptr_gray, to_gray(m_wr)); end
    end
    #1;
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b want 0", s_ready); end
    total++; if (wr_ptr_gray !== 4'b1100) begin bad++; $display("FAIL full_wptr: got %b want 1100", wr_ptr_gray); end
  endtask

  task automatic test_write_while_full();
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = W'($urandom());
      #1;
      total++; if (wea !== 1'b0) begin bad++; $display("FAIL wfull_wea[%0d]: got %b want 0", i, wea); end
      total++; if (addra !== 3'd0) begin bad++; $display("FAIL wfull_addr[%0d]: got %0d want 0", i, addra); end
      step();
      total++; if (wr_ptr_gray !== 4'b1100) begin bad++; $display("FAIL wfull_wptr[%0d]: got %b want 1100", i, wr_ptr_gray); end
    end
  endtask

  task automatic test_drain();
    s_valid = 1'b0;
    set_rd(4'd2);
    for (int i = 1; i <= 3; i++) begin
      step();
      total++; if (full !== (i < 3)) begin bad++; $display("FAIL drain_full[%0d]: got %b want %b", i, full, (i < 3)); end
    end
    total++; if (wr_count !== 4'd6) begin bad++; $display("FAIL drain_count: got %0d want 6", wr_count); end
    total++; if (almost_full !== 1'b1) begin bad++; $display("FAIL drain_af: got %b want 1", almost_full); end
    s_valid = 1'b1; s_data = 36'h9;
    #1;
    total++; if (wea !== 1'b1) begin bad++; $display("FAIL drain_wea: got %b want 1", wea); end
    total++; if (addra !== 3'd0) begin bad++; $display("FAIL drain_addr: got %0d want 0", addra); end
    step();
    s_valid = 1'b0;
    total++; if (wr_ptr_gray !== 4'b1101) begin bad++; $display("FAIL drain_wptr: got %b want 1101", wr_ptr_gray); end
    total++; if (wr_count !== m_cnt) begin bad++; $display("FAIL drain_count2: got %0d want %0d", wr_count, m_cnt); end
  endtask

  task automatic test_wrap();
    int nwr;
    logic [3:0] prev_g;
    s_valid = 1'b0;
    // Let the reader catch up to three behind, one step per cycle.
    for (int i = 0; i < 16 && ((m_wr - rd_bin) > 4'd3); i++) begin
      set_rd(rd_bin + 4'd1);
      step();
    end
    for (int i = 0; i < 3; i++) step();
    nwr = 0;
    for (int cyc = 0; cyc < 400 && nwr < 40; cyc++) begin
      if ((m_wr - rd_bin) > 4'd3) set_rd(rd_bin + 4'd1);
      s_valid = (($urandom() % 4) != 0);
      s_data  = W'({$urandom(), $urandom()});
      #1;
      total++; if (s_ready !== !m_full) begin bad++; $display("FAIL wrap_ready: got %b want %b", s_ready, !m_full); end
      total++; if (wea !== s_valid) begin bad++; $display("FAIL wrap_wea: got %b want %b", wea, s_valid); end
      if (s_valid) begin
        total++; if (addra !== m_wr[2:0]) begin bad++; $display("FAIL wrap_addr: got %0d want %0d", addra, m_wr[2:0]); end
        total++; if (dina !== s_data) begin bad++; $display("FAIL wrap_dina: got %h want %h", dina, s_data); end
      end
      prev_g = wr_ptr_gray;
      step();
      if (m_wea) nwr++;
      total++; if (full !== 1'b0) begin bad++; $display("FAIL wrap_full: got %b want 0", full); end
      total++; if (wr_count !== m_cnt) begin bad++; $display("FAIL wrap_count: got %0d want %0d", wr_count, m_cnt); end
      total++; if (almost_full !== m_af) begin bad++; $display("FAIL wrap_af: got %b want %b", almost_full, m_af); end
      total++; if (wr_ptr_gray !== to_gray(m_wr)) begin bad++; $display("FAIL wrap_wptr: got %b want %b", wr_ptr_gray, to_gray(m_wr)); end
      total++;
      if ($countones(prev_g ^ wr_ptr_gray) != (m_wea ? 1 : 0)) begin
        bad++; $display("FAIL wrap_gray_step: got %b->%b want %0d bit change", prev_g, wr_ptr_gray, m_wea ? 1 : 0);
      end
    end
    s_valid = 1'b0;
    total++; if (nwr != 40) begin bad++; $display("FAIL wrap_budget: got %0d writes want 40", nwr); end
  endtask

  task automatic test_mid_reset();
    rstb = 1'b1; s_valid = 1'b0; set_rd(4'd0);
    step();
    rstb = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = W'($urandom());
      #1;
      total++; if (addra !== 3'(i)) begin bad++; $display("FAIL mid_addr[%0d]: got %0d want %0d", i, addra, i); end
      step();
    end
    total++; if (wr_count !== 4'd5) begin bad++; $display("FAIL mid_count_pre: got %0d want 5", wr_count); end
    rstb = 1'b1;
    #1;
    total++; if (wea !== 1'b0) begin bad++; $display("FAIL mid_wea: got %b want 0", wea); end
    step();
    rstb = 1'b0;
    total++; if (wr_count !== 4'd0) begin bad++; $display("FAIL mid_count: got %0d want 0", wr_count); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL mid_full: got %b want 0", full); end
    total++; if (wr_ptr_gray !== 4'd0) begin bad++; $display("FAIL mid_wptr: got %b want 0", wr_ptr_gray); end
    #1;
    total++; if (wea !== 1'b1) begin bad++; $display("FAIL mid_wea_post: got %b want 1", wea); end
    total++; if (addra !== 3'd0) begin bad++; $display("FAIL mid_addr_post: got %0d want 0", addra); end
    step();
    s_valid = 1'b0;
    total++; if (wr_count !== 4'd1) begin bad++; $display("FAIL mid_count_post: got %0d want 1", wr_count); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write_while_full();
    test_drain();
    test_wrap();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
